brush_stamp_arbiter: RTL and testbench

Shares the canvas frame buffer's single pixel-write port between the local cursor stream and the remote (diff_rx) cursor stream. Accepts one brush stamp per requester handshake (x, y, color, stroke width), arbitrates round-robin, and expands each stamp into a clipped square of per-pixel writes with linear addresses. Sits between user_input2/comm latch and frame_buffer, in the pixel clock domain.

---
 rtl/brush_pkg.sv | 25 ++
 rtl/brush_stamp_arbiter_rr.sv | 41 ++++
 rtl/brush_stamp_arbiter.sv | 152 +++++++++++++++
 tb/tb_brush_stamp_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/brush_pkg.sv
// == brush_pkg: shared stamp record, canvas defaults and FSM encoding | rev 1.0 ==
`default_nettype none

package brush_pkg;

  localparam int H_RES_DEF  = 320;
  localparam int V_RES_DEF  = 180;
  localparam int ADDR_W_DEF = 16;

  // Field order matches the diff link code layout.
  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
    logic [3:0] color;
    logic [2:0] width;
  } stamp_t;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_STAMP = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/brush_stamp_arbiter_rr.sv
// == rr_arbiter2: two-requester round-robin grant, history updated only on acceptance | rev 1.0 ==
`default_nettype none

module rr_arbiter2
  import brush_pkg::*;
(
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [1:0] req_in,
  input  logic       en_in,
  output logic [1:0] grant_out
);

  logic last_q, last_d;

  always_comb begin
    grant_out = req_in;
    if (req_in == 2'b11) begin
      grant_out = last_q ? 2'b01 : 2'b10;
    end
  end

  always_comb begin
    last_d = last_q;
    if (en_in && (grant_out != 2'b00)) begin
      last_d = grant_out[1];
    end
  end

  // Reset to the remote side so local wins the first contention.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/brush_stamp_arbiter.sv
// == brush_stamp_arbiter: arbitrates local/remote brush stamps into clipped pixel writes | rev 1.0 ==
// == Optional BRUSH_DEDUP_EN: drop a request identical to that requester's last accepted stamp ==
`default_nettype none

module brush_stamp_arbiter
  import brush_pkg::*;
#(
  parameter int H_RES  = H_RES_DEF,
  parameter int V_RES  = V_RES_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [1:0]        req_valid_in,
  input  logic [1:0][9:0]   req_x_in,
  input  logic [1:0][8:0]   req_y_in,
  input  logic [1:0][3:0]   req_color_in,
  input  logic [1:0][2:0]   req_width_in,
  output logic [1:0]        req_ready_out,
  output logic              wr_valid_out,
  input  logic              wr_ready_in,
  output logic [ADDR_W-1:0] wr_addr_out,
  output logic [3:0]        wr_color_out,
  output logic              busy_out,
  output logic              stamp_done_out
);

  state_t      state_q, state_d;
  stamp_t      stamp_q, stamp_d;
  logic [2:0]  dx_q, dx_d, dy_q, dy_d;
  stamp_t      req_stamp [2];
  logic [1:0]  grant;
  logic        accept, gidx, dup, start;
  logic [10:0] px;
  logic [9:0]  py;
  logic        in_bounds, last_pos, advance;

  for (genvar i = 0; i < 2; i++) begin : g_req
    assign req_stamp[i] = {req_x_in[i], req_y_in[i], req_color_in[i], req_width_in[i]};
  end

  rr_arbiter2 u_arb (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .req_in    (req_valid_in),
    .en_in     (accept),
    .grant_out (grant)
  );

  assign accept = (state_q == ST_IDLE) && (req_valid_in != 2'b00);
  assign gidx   = grant[1];
  assign start  = accept && !dup;

`ifdef BRUSH_DEDUP_EN
  stamp_t     last_q [2];
  stamp_t     last_d [2];
  logic [1:0] last_vld_q, last_vld_d;

  always_comb begin
    last_d     = last_q;
    last_vld_d = last_vld_q;
    if (accept) begin
      last_d[gidx]     = req_stamp[gidx];
      last_vld_d[gidx] = 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      last_q     <= '{default: '0};
      last_vld_q <= 2'b00;
    end else begin
      last_q     <= last_d;
      last_vld_q <= last_vld_d;
    end
  end

  assign dup = last_vld_q[gidx] && (last_q[gidx] == req_stamp[gidx]);
`else
  assign dup = 1'b0;
`endif

  // Sums are widened by one bit so edge stamps clip instead of wrapping.
  assign px        = {1'b0, stamp_q.x} + {8'b0, dx_q};
  assign py        = {1'b0, stamp_q.y} + {7'b0, dy_q};
  assign in_bounds = (px < 11'(H_RES)) && (py < 10'(V_RES));
  assign last_pos  = (dx_q == stamp_q.width) && (dy_q == stamp_q.width);
  assign advance   = (state_q == ST_STAMP) && (!in_bounds || wr_ready_in);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_STAMP;
      ST_STAMP: if (advance && last_pos) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    stamp_d = stamp_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    if (start) begin
      stamp_d = req_stamp[gidx];
      dx_d    = 3'd0;
      dy_d    = 3'd0;
    end else if (advance) begin
      if (dx_q == stamp_q.width) begin
        dx_d = 3'd0;
        dy_d = dy_q + 3'd1;
      end else begin
        dx_d = dx_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      stamp_q <= '0;
      dx_q    <= 3'd0;
      dy_q    <= 3'd0;
    end else begin
      stamp_q <= stamp_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
    end
  end

  always_comb begin
    req_ready_out  = accept ? grant : 2'b00;
    busy_out       = (state_q == ST_STAMP);
    wr_valid_out   = (state_q == ST_STAMP) && in_bounds;
    wr_addr_out    = '0;
    wr_color_out   = 4'd0;
    stamp_done_out = advance && last_pos;
    if (wr_valid_out) begin
      wr_addr_out  = ADDR_W'(py) * ADDR_W'(H_RES) + ADDR_W'(px);
      wr_color_out = stamp_q.color;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_brush_stamp_arbiter.sv
// == tb_brush_stamp_arbiter: directed + randomized checks against a pixel-list reference model | rev 1.0 ==
`default_nettype none

module tb_brush_stamp_arbiter;

  localparam int HR = 320;
  localparam int VR = 180;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [1:0]      req_valid;
  logic [1:0][9:0] req_x;
  logic [1:0][8:0] req_y;
  logic [1:0][3:0] req_c;
  logic [1:0][2:0] req_w;
  logic [1:0]      req_ready;
  logic            wr_valid, wr_ready;
  logic [15:0]     wr_addr;
  logic [3:0]      wr_color;
  logic            busy, done;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int done_cnt = 0;
  int obs_q[$];
  int exp_q[$];
  int mlast;
  bit m_stamped;
  bit rnd_wr = 1'b0;
  int fx[2], fy[2], fc[2], fw[2];
`ifdef BRUSH_DEDUP_EN
  int lx[2], ly[2], lc[2], lw[2];
  bit lv[2];
`endif

  brush_stamp_arbiter dut (
    .clk_in         (clk),
    .rst_in         (rst_n),
    .req_valid_in   (req_valid),
    .req_x_in       (req_x),
    .req_y_in       (req_y),
    .req_color_in   (req_c),
    .req_width_in   (req_w),
    .req_ready_out  (req_ready),
    .wr_valid_out   (wr_valid),
    .wr_ready_in    (wr_ready),
    .wr_addr_out    (wr_addr),
    .wr_color_out   (wr_color),
    .busy_out       (busy),
    .stamp_done_out (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_valid && wr_ready) obs_q.push_back(int'({wr_addr, wr_color}));
      if (done) done_cnt++;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    if (rnd_wr) wr_ready = ($urandom_range(0, 3) != 0);
    @(negedge clk);
  endtask

  task automatic drive_req(input int r);
    req_x[r] = 10'(fx[r]);
    req_y[r] = 9'(fy[r]);
    req_c[r] = 4'(fc[r]);
    req_w[r] = 3'(fw[r]);
  endtask

  task automatic rand_fields(input int r);
    fx[r] = int'($urandom_range(0, 335));
    fy[r] = int'($urandom_range(0, 190));
    fc[r] = int'($urandom_range(0, 15));
    fw[r] = int'($urandom_range(0, 3));
  endtask

  // Reference: every accepted stamp is a (w+1)x(w+1) square, keep only on-canvas pixels in raster order.
  function automatic void model_accept(input int r);
    m_stamped = 1'b1;
`ifdef BRUSH_DEDUP_EN
    if (lv[r] && lx[r] == fx[r] && ly[r] == fy[r] && lc[r] == fc[r] && lw[r] == fw[r])
      m_stamped = 1'b0;
    lv[r] = 1'b1; lx[r] = fx[r]; ly[r] = fy[r]; lc[r] = fc[r]; lw[r] = fw[r];
`endif
    mlast = r;
    if (m_stamped) begin
      for (int dy = 0; dy <= fw[r]; dy++)
        for (int dx = 0; dx <= fw[r]; dx++)
          if (fx[r] + dx < HR && fy[r] + dy < VR)
            exp_q.push_back((((fy[r] + dy) * HR + fx[r] + dx) << 4) | fc[r]);
    end
  endfunction

  task automatic send(input int r, output int t);
    drive_req(r);
    req_valid[r] = 1'b1;
    #1;
    t = -1;
    for (int k = 0; k < 400; k++) begin
      if (req_ready[r]) begin
        t = cyc;
        break;
      end
      next_cycle();
    end
    if (t < 0) chk("accept_timeout", 0, 1);
    else begin
      chk("ready_onehot", 32'(req_ready), 32'(1 << r));
      model_accept(r);
    end
    @(posedge clk);
    #1;
    req_valid[r] = 1'b0;
    if (rnd_wr) wr_ready = ($urandom_range(0, 3) != 0);
    @(negedge clk);
  endtask

  task automatic wait_done(output int d);
    d = -1;
    for (int k = 0; k < 1000; k++) begin
      if (done) begin
        d = cyc;
        break;
      end
      next_cycle();
    end
    if (d < 0) chk("done_timeout", 0, 1);
  endtask

  task automatic cmp_q(input string tag);
    int n;
    chk({tag, "_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({tag, "_write"}, obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req_valid = 2'b00;
    #1;
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_valid", 32'(wr_valid), 0);
    chk("rst_addr", 32'(wr_addr), 0);
    chk("rst_color", 32'(wr_color), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    repeat (2) next_cycle();
    rst_n = 1'b1;
    mlast = 1;
`ifdef BRUSH_DEDUP_EN
    lv[0] = 1'b0;
    lv[1] = 1'b0;
`endif
    obs_q.delete();
    exp_q.delete();
    next_cycle();
  endtask

  initial begin
    int t, d, g, dc0;
    bit to;
    rst_n = 1'b0;
    req_valid = 2'b00;
    req_x = '0; req_y = '0; req_c = '0; req_w = '0;
    wr_ready = 1'b1;
    @(negedge clk);
    apply_reset();

    // Single-pixel local stamp
    fx[0] = 10; fy[0] = 20; fc[0] = 3; fw[0] = 0;
    send(0, t);
    chk("t1_valid", 32'(wr_valid), 1);
    chk("t1_addr", 32'(wr_addr), 6410);
    chk("t1_color", 32'(wr_color), 3);
    chk("t1_done", 32'(done), 1);
    chk("t1_latency", cyc, t + 1);
    repeat (2) next_cycle();
    chk("t1_busy_after", 32'(busy), 0);
    cmp_q("t1");

    // Corner stamp: 16 positions, 4 surviving pixels
    fx[0] = 318; fy[0] = 178; fc[0] = 6; fw[0] = 3;
    send(0, t);
    wait_done(d);
    chk("t2_done_latency", d - t, 16);
    repeat (2) next_cycle();
    if (obs_q.size() > 0) chk("t2_first_addr", obs_q[0] >> 4, 57278);
    cmp_q("t2");

    // Contention from reset: grants alternate, starting local
    apply_reset();
    rnd_wr = 1'b1;
    rand_fields(0); rand_fields(1);
    drive_req(0); drive_req(1);
    req_valid = 2'b11;
    #1;
    for (int k = 0; k < 10; k++) begin
      to = 1'b1;
      for (int j = 0; j < 400; j++) begin
        if (req_ready != 2'b00) begin
          to = 1'b0;
          break;
        end
        next_cycle();
      end
      if (to) begin
        chk("t3_grant_timeout", 0, 1);
        break;
      end
      g = (mlast == 1) ? 0 : 1;
      chk("t3_grant", 32'(req_ready), 32'(1 << g));
      model_accept(g);
      @(posedge clk);
      #1;
      rand_fields(g);
      drive_req(g);
      wr_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      #1;
    end
    req_valid = 2'b00;
    for (int j = 0; j < 400 && busy; j++) next_cycle();
    repeat (2) next_cycle();
    cmp_q("t3");

    // Back-pressure on the second pixel of a w=1 stamp
    rnd_wr = 1'b0;
    wr_ready = 1'b1;
    fx[0] = 5; fy[0] = 5; fc[0] = 9; fw[0] = 1;
    send(0, t);
    @(posedge clk);
    #1;
    wr_ready = 1'b0;
    @(negedge clk);
    chk("t4_stall_addr", 32'(wr_addr), 1606);
    chk("t4_stall_color", 32'(wr_color), 9);
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      chk("t4_hold_addr", 32'(wr_addr), 1606);
      chk("t4_hold_valid", 32'(wr_valid), 1);
    end
    @(posedge clk);
    #1;
    wr_ready = 1'b1;
    @(negedge clk);
    wait_done(d);
    repeat (2) next_cycle();
    cmp_q("t4");

    // Reset in the middle of a large stamp
    fx[1] = 0; fy[1] = 0; fc[1] = 5; fw[1] = 7;
    send(1, t);
    repeat (3) next_cycle();
    dc0 = done_cnt;
    apply_reset();
    chk("t5_no_partial_done", done_cnt - dc0, 0);
    fx[1] = 100; fy[1] = 100; fc[1] = 7; fw[1] = 1;
    send(1, t);
    chk("t5_first_addr", 32'(wr_addr), 32100);
    wait_done(d);
    repeat (2) next_cycle();
    chk("t5_done_count", done_cnt - dc0, 1);
    cmp_q("t5");

    // Repeated identical stamp, then a colour change
    fx[0] = 50; fy[0] = 60; fc[0] = 2; fw[0] = 1;
    send(0, t);
    wait_done(d);
    repeat (2) next_cycle();
    cmp_q("t6a");
    dc0 = done_cnt;
    send(0, t);
    chk("t6_busy", 32'(busy), 32'(m_stamped));
    if (m_stamped) wait_done(d);
    repeat (3) next_cycle();
    chk("t6_done_count", done_cnt - dc0, 32'(m_stamped));
    cmp_q("t6b");
    fc[0] = 4;
    send(0, t);
    wait_done(d);
    repeat (2) next_cycle();
    cmp_q("t6c");

    // Random single-requester stamps with random back-pressure
    rnd_wr = 1'b1;
    for (int k = 0; k < 14; k++) begin
      g = int'($urandom_range(0, 1));
      rand_fields(g);
      send(g, t);
      if (m_stamped) wait_done(d);
    end
    rnd_wr = 1'b0;
    wr_ready = 1'b1;
    repeat (3) next_cycle();
    cmp_q("t7");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
